// File: rtl/ncl_sync_sink_pkg.sv
// ============================================================================
// Module : ncl_sync_sink_pkg
// Brief  : Shared state encodings and helpers for the NCL synchronizing sink.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ncl_sync_sink_pkg;

   typedef enum logic [1:0] {
      FLUSH = 2'd0,
      IDLE  = 2'd1,
      HOLD  = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ncl_sync_fifo.sv
// ============================================================================
// Module : ncl_sync_fifo
// Brief  : Show-ahead valid/ready FIFO; a token written into an empty FIFO
//          becomes visible on the following edge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ncl_sync_fifo
   import ncl_sync_sink_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    init_n,
   input  logic                    wr_en,
   input  logic [WIDTH-1:0]        wr_data,
   input  logic                    rd_ready,
   output logic [WIDTH-1:0]        rd_data,
   output logic                    rd_valid,
   output logic [clog2(DEPTH):0]   fill
);

   localparam int              c_aw    = clog2(DEPTH);
   localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_fill;
   logic [c_aw:0]    w_fill_next;
   logic             r_valid;
   logic             w_pop;
   logic             w_push;

   assign w_pop  = r_valid & rd_ready;
   assign w_push = wr_en & ((r_fill != c_depth) | w_pop);

   always_comb begin
      w_fill_next = r_fill;
      if (w_push & ~w_pop)
         w_fill_next = r_fill + 1'b1;
      else if (w_pop & ~w_push)
         w_fill_next = r_fill - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!init_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
         r_valid  <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_fill  <= w_fill_next;
         // Held low for one cycle after a write into an empty FIFO.
         r_valid <= (r_fill != '0) & (w_fill_next != '0);
      end
   end

   assign rd_data  = r_valid ? r_mem[r_rd_ptr] : '0;
   assign rd_valid = r_valid;
   assign fill     = r_fill;

endmodule

`default_nettype wire

// File: rtl/ncl_sync_sink.sv
// ============================================================================
// Module : ncl_sync_sink
// Brief  : Clocked sink for a dual-rail NCL pipeline: synchronizes rails,
//          detects completeness, drives completion and buffers tokens.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ncl_sync_sink
   import ncl_sync_sink_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    init_n,
   input  logic [WIDTH-1:0]        in_t,
   input  logic [WIDTH-1:0]        in_f,
   output logic                    in_comp,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [clog2(DEPTH):0]   fill,
   output logic                    err
);

   localparam int              c_aw    = clog2(DEPTH);
   localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync_t;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync_f;
   logic [SYNC_STAGES-1:0]            r_primed;
   logic [WIDTH-1:0]                  w_st;
   logic [WIDTH-1:0]                  w_sf;
   logic                              w_all_data;
   logic                              w_all_null;
   logic                              w_illegal;
   logic                              w_can_push;
   logic                              w_push;
   state_t                            r_state;
   state_t                            w_next;
   logic                              r_comp;
   logic                              r_err;

   // Primed bits keep the FSM from trusting the cleared synchronizer
   // until real pin samples have reached the last stage.
   always_ff @(posedge clk) begin
      if (!init_n) begin
         r_sync_t <= '0;
         r_sync_f <= '0;
         r_primed <= '0;
      end else begin
         r_sync_t[0] <= in_t;
         r_sync_f[0] <= in_f;
         r_primed[0] <= 1'b1;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync_t[i] <= r_sync_t[i-1];
            r_sync_f[i] <= r_sync_f[i-1];
            r_primed[i] <= r_primed[i-1];
         end
      end
   end

   assign w_st       = r_sync_t[SYNC_STAGES-1];
   assign w_sf       = r_sync_f[SYNC_STAGES-1];
   assign w_illegal  = |(w_st & w_sf);
   assign w_all_data = r_primed[SYNC_STAGES-1] & (&(w_st ^ w_sf));
   assign w_all_null = r_primed[SYNC_STAGES-1] & ~(|(w_st | w_sf));
   assign w_can_push = (fill < c_depth) | (out_valid & out_ready);

   always_comb begin
      w_next = r_state;
      w_push = 1'b0;
      case (r_state)
         FLUSH: if (w_all_null) w_next = IDLE;
         IDLE: begin
            if (w_all_data & w_can_push) begin
               w_push = 1'b1;
               w_next = HOLD;
            end
         end
         HOLD:  if (w_all_null) w_next = IDLE;
         default: w_next = FLUSH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!init_n) begin
         r_state <= FLUSH;
         r_comp  <= 1'b1;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_comp  <= (w_next != IDLE);
         r_err   <= r_err | w_illegal;
      end
   end

   assign in_comp = r_comp;
   assign err     = r_err;

   ncl_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .init_n   (init_n),
      .wr_en    (w_push),
      .wr_data  (w_st),
      .rd_ready (out_ready),
      .rd_data  (out_data),
      .rd_valid (out_valid),
      .fill     (fill)
   );

endmodule

`default_nettype wire

// File: tb/tb_ncl_sync_sink.sv
// ============================================================================
// Module : tb_ncl_sync_sink
// Brief  : Directed and randomized bench for ncl_sync_sink against a
//          token-level model of the NCL handshake and FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ncl_sync_sink;

   localparam int WIDTH       = 8;
   localparam int DEPTH       = 4;
   localparam int SYNC_STAGES = 2;

   logic             clk = 1'b0;
   logic             init_n;
   logic [WIDTH-1:0] in_t;
   logic [WIDTH-1:0] in_f;
   logic             in_comp;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [2:0]       fill;
   logic             err;

   always #5 clk = ~clk;

   ncl_sync_sink #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk       (clk),
      .init_n    (init_n),
      .in_t      (in_t),
      .in_f      (in_f),
      .in_comp   (in_comp),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fill      (fill),
      .err       (err)
   );

   // Token-level model: pins seen SYNC_STAGES edges late; comp=1 waits for
   // NULL, comp=0 waits for a complete DATA word with room to store it.
   logic [WIDTH-1:0] m_hist_t [$];
   logic [WIDTH-1:0] m_hist_f [$];
   logic [WIDTH-1:0] m_q [$];
   logic [WIDTH-1:0] got [$];
   int               m_age;
   bit               m_comp;
   bit               m_valid;
   bit               m_err;
   bit               rnd_ready;
   int               n_checks;
   int               n_fail;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [WIDTH-1:0] st, sf;
      bit trusted, all_d, all_n, pop, push;
      int size_pre;
      if (!init_n) begin
         m_hist_t.delete();
         m_hist_f.delete();
         repeat (SYNC_STAGES) begin
            m_hist_t.push_back('0);
            m_hist_f.push_back('0);
         end
         m_q.delete();
         m_age   = 0;
         m_comp  = 1'b1;
         m_valid = 1'b0;
         m_err   = 1'b0;
      end else begin
         st       = m_hist_t[SYNC_STAGES-1];
         sf       = m_hist_f[SYNC_STAGES-1];
         trusted  = (m_age >= SYNC_STAGES);
         all_d    = trusted && ((st ^ sf) == '1);
         all_n    = trusted && ((st | sf) == '0);
         size_pre = m_q.size();
         pop      = m_valid && out_ready;
         push     = 1'b0;
         if (m_comp && all_n)
            m_comp = 1'b0;
         else if (!m_comp && all_d && (size_pre < DEPTH || pop)) begin
            push   = 1'b1;
            m_comp = 1'b1;
         end
         if (pop)  void'(m_q.pop_front());
         if (push) m_q.push_back(st);
         m_valid = (size_pre != 0) && (m_q.size() != 0);
         if ((st & sf) != '0) m_err = 1'b1;
         if (m_age < 100) m_age++;
         m_hist_t.push_front(in_t);
         m_hist_f.push_front(in_f);
         void'(m_hist_t.pop_back());
         void'(m_hist_f.pop_back());
      end
   endtask

   task automatic step();
      logic [WIDTH-1:0] d_pre;
      bit pop_pre;
      pop_pre = (init_n === 1'b1) && (out_valid === 1'b1) && (out_ready === 1'b1);
      d_pre   = out_data;
      @(posedge clk);
      model_edge();
      if (pop_pre) got.push_back(d_pre);
      #1;
      check("comp",  in_comp,   m_comp);
      check("valid", out_valid, m_valid);
      check("fill",  fill,      m_q.size());
      check("err",   err,       m_err);
      if (m_valid) check("data", out_data, m_q[0]);
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_comp(input bit val, input int budget, input string tag);
      int n;
      n = 0;
      while (in_comp !== val && n < budget) begin
         step();
         n++;
      end
      check(tag, in_comp, val);
   endtask

   task automatic put_data(input logic [WIDTH-1:0] v);
      in_t = v;
      in_f = ~v;
   endtask

   task automatic put_null();
      in_t = '0;
      in_f = '0;
   endtask

   task automatic send(input logic [WIDTH-1:0] v);
      put_data(v);
      wait_comp(1'b1, 40, "send_ack");
      put_null();
      wait_comp(1'b0, 40, "send_rel");
   endtask

   initial begin
      logic [WIDTH-1:0] v, mask;
      n_checks  = 0;
      n_fail    = 0;
      rnd_ready = 1'b0;
      init_n    = 1'b0;
      out_ready = 1'b0;
      put_null();

      // Reset and start-up latency
      repeat (3) step();
      check("rst_comp",  in_comp,   1);
      check("rst_valid", out_valid, 0);
      check("rst_data",  out_data,  0);
      check("rst_fill",  fill,      0);
      init_n = 1'b1;
      step(); check("start_e1", in_comp, 1);
      step(); check("start_e2", in_comp, 1);
      step(); check("start_e3", in_comp, 0);

      // Single token latency
      out_ready = 1'b1;
      put_data(8'hA5);
      step(); step();
      check("t2_e2", in_comp, 0);
      step();
      check("t2_comp", in_comp, 1);
      check("t2_fill", fill, 1);
      check("t2_valid_lag", out_valid, 0);
      step();
      check("t2_valid", out_valid, 1);
      check("t2_data", out_data, 8'hA5);
      put_null();
      step(); step();
      check("t2_null_e2", in_comp, 1);
      step();
      check("t2_null_e3", in_comp, 0);

      // Ramp one bit every 5 cycles
      out_ready = 1'b0;
      v = 8'h96;
      for (int b = 0; b < WIDTH; b++) begin
         in_t[b] = v[b];
         in_f[b] = ~v[b];
         repeat (5) step();
         if (b < WIDTH - 1) begin
            check("t3_nopush", fill, 0);
            check("t3_nocomp", in_comp, 0);
         end
      end
      check("t3_push", fill, 1);
      check("t3_comp", in_comp, 1);
      repeat (10) step();
      check("t3_once", fill, 1);
      put_null();
      wait_comp(1'b0, 20, "t3_rel");
      out_ready = 1'b1;
      repeat (3) step();
      check("t3_drain", fill, 0);

      // Backpressure: FIFO full, fifth token held upstream
      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) send(8'(k));
      check("t4_full", fill, 4);
      put_data(8'h05);
      repeat (8) step();
      check("t4_held_comp", in_comp, 0);
      check("t4_held_fill", fill, 4);
      got.delete();
      out_ready = 1'b1;
      wait_comp(1'b1, 20, "t4_cap");
      put_null();
      repeat (20) step();
      check("t4_count", got.size(), 5);
      for (int k = 0; k < 5 && k < got.size(); k++)
         check("t4_order", got[k], k + 1);

      // Illegal bit pulse
      in_t = 8'hA5 | 8'h08;
      in_f = 8'h5A | 8'h08;
      step();
      put_null();
      repeat (6) step();
      check("t5_err", err, 1);
      check("t5_fill", fill, 0);
      check("t5_comp", in_comp, 0);
      send(8'h11);
      repeat (4) step();
      check("t5_sticky", err, 1);

      // Reset while holding a token with two entries buffered
      out_ready = 1'b0;
      send(8'h21);
      put_data(8'h22);
      wait_comp(1'b1, 20, "t6_hold");
      check("t6_fill2", fill, 2);
      init_n = 1'b0;
      repeat (2) step();
      check("t6_rst_fill",  fill,      0);
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_comp",  in_comp,   1);
      check("t6_rst_err",   err,       0);
      init_n = 1'b1;
      repeat (6) step();
      check("t6_flush_comp", in_comp, 1);
      check("t6_flush_fill", fill, 0);
      put_null();
      wait_comp(1'b0, 20, "t6_resume");
      got.delete();
      out_ready = 1'b1;
      send(8'h3C);
      repeat (6) step();
      check("t6_count", got.size(), 1);
      if (got.size() > 0) check("t6_first", got[0], 8'h3C);

      // Randomized wavefronts with random consumer stalls
      rnd_ready = 1'b1;
      repeat (40) begin
         v    = 8'($urandom);
         mask = 8'($urandom);
         in_t = v & mask;
         in_f = ~v & mask;
         repeat ($urandom_range(0, 3)) step();
         put_data(v);
         wait_comp(1'b1, 80, "rnd_ack");
         repeat ($urandom_range(0, 4)) step();
         mask = 8'($urandom);
         in_t = in_t & mask;
         in_f = in_f & mask;
         repeat ($urandom_range(0, 3)) step();
         put_null();
         wait_comp(1'b0, 80, "rnd_rel");
      end
      rnd_ready = 1'b0;
      out_ready = 1'b1;
      repeat (10) step();
      check("rnd_drain", fill, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
